fifo_rd_streamer: RTL and testbench
===================================

// Module: fifo_rd_streamer
// PURPOSE
//  Read-side master for the team's dual-clock FIFO, in the read clock domain.
//  Drives the FIFO read port, where read data is registered and valid one cycle after ren.
//  Repackages the words into a valid/ready stream using an internal skid buffer.
//  Start/stop control with a drained-idle indication, plus a count of delivered words.
// PARAMETERS
//  DATA_WIDTH  32  width of fifo_rdata_i / m_data_o
//  OUT_DEPTH   4   output buffer entries; min 2; >=3 required for 1 word/cycle
//  CNT_WIDTH   16  width of word_cnt_o
// PORTS
//  clk_i         in   1           read-domain clock
//  rst_i         in   1           synchronous, active-high reset
//  en_i          in   1           1 = fetch from FIFO; 0 = stop and drain
//  fifo_empty_i  in   1           FIFO empty flag, same clock domain
//  fifo_ren_o    out  1           FIFO read enable
//  fifo_rdata_i  in   DATA_WIDTH  FIFO read data, valid the cycle after fifo_ren_o
//  m_valid_o     out  1           output word valid
//  m_data_o      out  DATA_WIDTH  output word
//  m_ready_i     in   1           downstream accept
//  idle_o        out  1           1 = state IDLE; no read in flight and buffer empty
//  word_cnt_o    out  CNT_WIDTH   accepted output beats, wraps modulo 2^CNT_WIDTH
// BEHAVIOUR
//  Reset (rst_i high at posedge):
//   - state=IDLE; occ=0; inflight=0; word_cnt_o=0; m_data_o=0.
//   - Outputs m_valid_o=0, fifo_ren_o=0, idle_o=1.
//   - fifo_ren_o is forced 0 in any cycle where rst_i=1.
//  FSM, 3 states:
//   - IDLE: en_i=1 -> RUN.
//   - RUN:  en_i=0 -> STOP.
//   - STOP: en_i=1 -> RUN; else if inflight=0 and occ=0 -> IDLE.
//  Read issue (combinational):
//   - fifo_ren_o = (state==RUN) & ~fifo_empty_i & (occ + inflight < OUT_DEPTH).
//   - No combinational path from m_ready_i or en_i to fifo_ren_o.
//   - Never read while fifo_empty_i=1: no underflow.
//   - Never read without a reserved buffer slot: no overflow.
//  Data capture:
//   - inflight <= fifo_ren_o, a 1-bit register.
//   - When inflight=1, fifo_rdata_i is pushed into the buffer at that cycle's posedge.
//   - When inflight=0, fifo_rdata_i is ignored.
//  Latency:
//   - fifo_ren_o at cycle n -> word at buffer head, m_valid_o=1, from cycle n+2 (if ahead-empty).
//   - en_i rising in IDLE -> earliest fifo_ren_o 1 cycle later.
//  Output handshake:
//   - m_valid_o = (occ!=0); m_data_o = head entry; strict FIFO order.
//   - While m_valid_o=1 and m_ready_i=0, m_data_o is held stable.
//   - Beat = m_valid_o & m_ready_i; it pops the head.
//   - Push and pop in the same cycle: occ unchanged, order preserved.
//  Counter:
//   - word_cnt_o += 1 per beat; wraps all-ones -> 0.
//   - Not cleared by en_i; cleared only by reset.
//  en_i deassert:
//   - No new reads from the next cycle.
//   - The in-flight word is still captured; the buffered words still drain.
//   - idle_o rises the cycle after the last beat.
//  Reset mid-operation:
//   - Buffered and in-flight words are discarded.
//   - The FIFO read pointer is not rewound, so the system must reset both ends together.
//  occ width: clog2(OUT_DEPTH+1); occ + inflight computed without truncation.
// TESTING
//  1. rst_i=1 with en_i=1, fifo_empty_i=0 -> fifo_ren_o=0, m_valid_o=0, idle_o=1, word_cnt_o=0.
//  2. FIFO model holds 0x01..0x10; en_i=1, m_ready_i=1 from cycle 0 ->
//     - first m_valid_o at cycle 3, then 16 back-to-back beats 0x01..0x10;
//     - word_cnt_o=16, then idle_o=1 after en_i=0.
//  3. m_ready_i=0 with FIFO full -> exactly OUT_DEPTH (4) reads, m_data_o held at 0x01;
//     release m_ready_i -> 0x01..0x10 delivered in order, no loss or duplication.
//  4. fifo_empty_i toggled pseudo-randomly -> fifo_ren_o never 1 while fifo_empty_i=1;
//     output sequence matches the FIFO contents.
//  5. en_i dropped while fifo_ren_o=1 -> no further reads; the in-flight word plus buffered words emitted;
//     idle_o=1 only after occ=0.
//  6. rst_i pulsed one cycle after fifo_ren_o -> m_valid_o=0 next cycle; that word is never emitted.
//  7. CNT_WIDTH=4, 17 beats -> word_cnt_o=1.

Source files
------------

// File: rtl/fifo_rd_streamer.sv
// Purpose: read-side master for a dual-clock FIFO; turns registered FIFO reads into a valid/ready stream.
// Latency: fifo_ren_o in cycle n -> word at m_data_o with m_valid_o=1 from cycle n+2 (buffer ahead empty);
//          en_i rising in IDLE -> earliest fifo_ren_o one cycle later.
// Backpressure: reads are only issued when a buffer slot is reserved, so m_ready_i low stalls reads, never drops.
//
// Ports:
//   clk_i, rst_i          read-domain clock, synchronous active-high reset
//   en_i                  1 = fetch from FIFO, 0 = stop issuing reads and drain
//   fifo_empty_i          FIFO empty flag (same clock domain)
//   fifo_ren_o            FIFO read enable
//   fifo_rdata_i          FIFO read data, valid the cycle after fifo_ren_o
//   m_valid_o/m_data_o    output stream word, held while m_ready_i is low
//   m_ready_i             downstream accept
//   idle_o                IDLE state: no read in flight, buffer empty
//   word_cnt_o            accepted output beats, wraps
module fifo_rd_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_DEPTH  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_ren_o,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  input  logic                  m_ready_i,
  output logic                  idle_o,
  output logic [CNT_WIDTH-1:0]  word_cnt_o
);

  localparam int OCC_W = $clog2(OUT_DEPTH + 1);
  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam int LAST  = OUT_DEPTH - 1;
  localparam logic [OCC_W:0]   DEPTH_C  = OUT_DEPTH[OCC_W:0];
  localparam logic [PTR_W-1:0] LAST_PTR = LAST[PTR_W-1:0];

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic                  inflight_q;
  logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
  logic [DATA_WIDTH-1:0] buf_q [OUT_DEPTH];
  logic [OCC_W:0]        reserved;
  logic                  push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Slots already committed: words held plus the word returning next cycle.
  // One extra bit so the sum never truncates.
  assign reserved = {1'b0, occ_q} + {{OCC_W{1'b0}}, inflight_q};

  // Depends only on registered state, the empty flag and reset; en_i and
  // m_ready_i reach it only through registers.
  assign fifo_ren_o = ~rst_i & (state_q == ST_RUN) & ~fifo_empty_i & (reserved < DEPTH_C);

  assign push      = inflight_q;
  assign m_valid_o = (occ_q != '0);
  assign pop       = m_valid_o & m_ready_i;
  assign m_data_o  = buf_q[rd_ptr_q];
  assign idle_o    = (state_q == ST_IDLE);

  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // STOP looks at the next-cycle occupancy so idle_o rises the cycle right
  // after the last beat. No reads issue in STOP, so next inflight is 0, and a
  // word still in flight keeps occ_d non-zero.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en_i) state_d = ST_RUN;
      ST_RUN:  if (!en_i) state_d = ST_STOP;
      ST_STOP: begin
        if (en_i)              state_d = ST_RUN;
        else if (occ_d == '0)  state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      word_cnt_o <= '0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      inflight_q <= fifo_ren_o;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop) begin
        rd_ptr_q   <= ptr_inc(rd_ptr_q);
        word_cnt_o <= word_cnt_o + 1'b1;
      end
    end
  end

  // Entries cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < OUT_DEPTH; i++) buf_q[i] <= '0;
    end else if (push) begin
      buf_q[wr_ptr_q] <= fifo_rdata_i;
    end
  end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Bench for fifo_rd_streamer: FIFO model, scoreboard queue filled at load time,
// monitor popping on every output beat, and directed checks per scenario.
module tb_fifo_rd_streamer;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, m_ready, gate_empty;
  logic          fifo_empty, ren, ren4;
  logic [DW-1:0] rdata = '0;
  logic          m_valid, m_valid4, idle, idle4;
  logic [DW-1:0] m_data, m_data4;
  logic [15:0]   cnt16;
  logic [3:0]    cnt4;

  logic [DW-1:0] fifo_mem [0:255];
  int            wr_idx = 0;
  int            rd_idx = 0;
  logic [DW-1:0] exp_q [$];
  int            nvec = 0;
  int            nerr = 0;
  int            ren_cnt = 0;
  int            beat_cnt = 0;

  fifo_rd_streamer #(.DATA_WIDTH(DW), .OUT_DEPTH(4), .CNT_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .fifo_empty_i(fifo_empty),
    .fifo_ren_o(ren), .fifo_rdata_i(rdata), .m_valid_o(m_valid),
    .m_data_o(m_data), .m_ready_i(m_ready), .idle_o(idle), .word_cnt_o(cnt16)
  );

  // Narrow-counter copy on identical stimulus, used for the wrap check.
  fifo_rd_streamer #(.DATA_WIDTH(DW), .OUT_DEPTH(4), .CNT_WIDTH(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .fifo_empty_i(fifo_empty),
    .fifo_ren_o(ren4), .fifo_rdata_i(rdata), .m_valid_o(m_valid4),
    .m_data_o(m_data4), .m_ready_i(m_ready), .idle_o(idle4), .word_cnt_o(cnt4)
  );

  // FIFO read port model: registered data, pointer never rewound by rst.
  assign fifo_empty = (rd_idx == wr_idx) || gate_empty;
  always @(posedge clk) begin
    if (ren) begin
      rdata  <= fifo_mem[rd_idx[7:0]];
      rd_idx <= rd_idx + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] base, input int n, input bit expect_out);
    for (int i = 0; i < n; i++) begin
      fifo_mem[wr_idx[7:0]] = base + i;
      if (expect_out) exp_q.push_back(base + i);
      wr_idx++;
    end
  endtask

  task automatic drain(input string name, input int max_cyc);
    int k = 0;
    while (exp_q.size() != 0 && k < max_cyc) begin
      tick();
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (!idle && k < 20) begin
      tick();
      k++;
    end
    check(name, {31'b0, idle}, 1);
  endtask

  initial begin
    int k, n, r0, b0;
    rst = 1'b1; en = 1'b1; m_ready = 1'b1; gate_empty = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          if (ren) ren_cnt++;
          if (fifo_empty) check("no_underflow", {31'b0, ren}, 0);
          if (m_valid && m_ready) begin
            beat_cnt++;
            if (exp_q.size() == 0) begin
              nvec++;
              nerr++;
              $display("FAIL unexpected_beat: got %0h, required no beat", m_data);
            end else begin
              check("stream_data", m_data, exp_q.pop_front());
            end
          end
        end
      end
    join_none

    // 1: reset with enable high and FIFO non-empty
    load(32'h01, 16, 1'b1);
    tick(); tick();
    check("rst_ren", {31'b0, ren}, 0);
    check("rst_ren_narrow", {31'b0, ren4}, 0);
    check("rst_valid", {31'b0, m_valid}, 0);
    check("rst_idle", {31'b0, idle}, 1);
    check("rst_cnt", {16'b0, cnt16}, 0);
    check("rst_data", m_data, 0);
    rst = 1'b0; en = 1'b0;
    tick(); tick();
    check("idle_no_en", {31'b0, idle}, 1);

    // 2: streaming at full rate
    en = 1'b1;
    k = 0;
    while (!m_valid && k < 10) begin
      tick();
      k++;
    end
    check("first_valid_latency", k, 3);
    check("run_not_idle", {31'b0, idle}, 0);
    n = 0;
    while (m_valid && n < 20) begin
      tick();
      n++;
    end
    check("b2b_beats", n, 16);
    check("cnt_after_16", {16'b0, cnt16}, 16);
    check("queue_empty_2", exp_q.size(), 0);
    en = 1'b0;
    wait_idle("idle_after_stop_2");

    // 3: downstream stalled, FIFO full
    m_ready = 1'b0;
    r0 = ren_cnt; b0 = beat_cnt;
    load(32'h01, 16, 1'b1);
    en = 1'b1;
    repeat (12) tick();
    check("stall_reads", ren_cnt - r0, 4);
    check("stall_valid", {31'b0, m_valid}, 1);
    check("stall_head", m_data, 32'h01);
    repeat (3) tick();
    check("stall_hold", m_data, 32'h01);
    m_ready = 1'b1;
    drain("stall_release", 80);
    check("stall_beats", beat_cnt - b0, 16);
    en = 1'b0;
    wait_idle("idle_after_stop_3");

    // 4: empty flag toggled, random ready
    load(32'h21, 16, 1'b1);
    en = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      gate_empty = 1'($urandom_range(0, 1));
      m_ready    = ($urandom_range(0, 3) != 0);
      tick();
      k++;
    end
    check("gated_drain", exp_q.size(), 0);
    gate_empty = 1'b0; m_ready = 1'b1;
    en = 1'b0;
    wait_idle("idle_after_stop_4");

    // 5: en dropped during the third read
    m_ready = 1'b0;
    r0 = ren_cnt;
    load(32'h41, 8, 1'b1);
    en = 1'b1;
    k = 0;
    while ((ren_cnt - r0) < 2 && k < 10) begin
      tick();
      k++;
    end
    check("drop_during_read", {31'b0, ren}, 1);
    en = 1'b0;
    repeat (6) tick();
    check("stop_reads", ren_cnt - r0, 3);
    check("stop_valid", {31'b0, m_valid}, 1);
    check("stop_not_idle", {31'b0, idle}, 0);
    m_ready = 1'b1;
    b0 = beat_cnt;
    n = 0;
    while (m_valid && n < 10) begin
      check("drain_not_idle", {31'b0, idle}, 0);
      tick();
      n++;
    end
    check("stop_drained_beats", beat_cnt - b0, 3);
    check("idle_after_last", {31'b0, idle}, 1);
    en = 1'b1;
    drain("resume_drain", 40);
    en = 1'b0;
    wait_idle("idle_after_stop_5");

    // 6: reset while a word is in flight
    load(32'h99, 1, 1'b0);
    en = 1'b1;
    k = 0;
    while (!ren && k < 10) begin
      tick();
      k++;
    end
    check("rst_test_read", {31'b0, ren}, 1);
    tick();
    rst = 1'b1; en = 1'b0;
    tick();
    check("rst_mid_valid", {31'b0, m_valid}, 0);
    check("rst_mid_cnt", {16'b0, cnt16}, 0);
    check("rst_mid_idle", {31'b0, idle}, 1);
    rst = 1'b0;
    b0 = beat_cnt;
    repeat (6) tick();
    check("rst_discard_valid", {31'b0, m_valid}, 0);
    check("rst_discard_beats", beat_cnt - b0, 0);

    // 7: narrow counter wraps after 17 beats
    load(32'h61, 17, 1'b1);
    en = 1'b1;
    drain("wrap_drain", 100);
    tick();
    check("cnt4_wrap", {28'b0, cnt4}, 1);
    check("cnt16_17", {16'b0, cnt16}, 17);
    en = 1'b0;
    wait_idle("idle_after_stop_7");

    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
